// File: rtl/matrix_frame_capture.sv
// matrix_frame_capture
//   Receive side of the LED-matrix GPIO loopback. Watches the row-scanned
//   red/green column drives and the row-sink lines and rebuilds complete 8x8
//   red and green frames for self-check and on-board debug.
//
// Parameters
//   ROW_ACTIVE_LOW  1: row_sink bit low selects the row; 0: high selects it
//   SETTLE          stable synchronized cycles before a row is captured (>= 2)
//   TIMEOUT         cycles without a capture before a partial frame is dropped
//
// Ports
//   CLOCK_50      in   50 MHz clock, posedge
//   reset         in   synchronous, active-high
//   red_driver    in   [7:0] red column drive (asynchronous)
//   green_driver  in   [7:0] green column drive (asynchronous)
//   row_sink      in   [7:0] row select lines (asynchronous)
//   red_frame     out  [63:0] last complete red frame, bit 8*r+c
//   green_frame   out  [63:0] last complete green frame, bit 8*r+c
//   frame_valid   out  one-cycle pulse when the frames update
//   frame_count   out  [7:0] completed frames, wrapping
//   row_error     out  sticky: more than one row selected at once
//   stale         out  timeout expired since the last completed frame
module matrix_frame_capture #(
    parameter bit          ROW_ACTIVE_LOW = 1'b1,
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 2**20
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  red_driver,
    input  logic [7:0]  green_driver,
    input  logic [7:0]  row_sink,
    output logic [63:0] red_frame,
    output logic [63:0] green_frame,
    output logic        frame_valid,
    output logic [7:0]  frame_count,
    output logic        row_error,
    output logic        stale
);

    localparam int unsigned CW       = $clog2(SETTLE);
    localparam int unsigned TW       = $clog2(TIMEOUT);
    localparam logic [7:0]  ROW_IDLE = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } state_t;

    state_t state, state_n;

    logic [7:0]    red_m, red_s, green_m, green_s, row_m, row_s;
    logic [7:0]    sel;
    logic          sel_onehot, sel_multi, sel_changed, any_changed;

    logic [7:0]    snap_sel, snap_red, snap_green;
    logic [2:0]    snap_row;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic [63:0]   shadow_red, shadow_green;
    logic [7:0]    seen, row_bit;
    logic          done_pend;

    logic          snap_load, cnt_clr, cnt_inc, capture, err_set;

    function automatic logic [2:0] row_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Row sync flops reset to the idle level so that sel reads as blanking
    // (not all rows selected) while the pipeline refills after reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            red_m   <= '0;
            red_s   <= '0;
            green_m <= '0;
            green_s <= '0;
            row_m   <= ROW_IDLE;
            row_s   <= ROW_IDLE;
        end else begin
            red_m   <= red_driver;
            red_s   <= red_m;
            green_m <= green_driver;
            green_s <= green_m;
            row_m   <= row_sink;
            row_s   <= row_m;
        end
    end

    assign sel         = ROW_ACTIVE_LOW ? ~row_s : row_s;
    assign sel_onehot  = (sel != '0) && ((sel & (sel - 8'd1)) == '0);
    assign sel_multi   = (sel != '0) && !sel_onehot;
    assign sel_changed = (sel != snap_sel);
    assign any_changed = sel_changed || (red_s != snap_red) || (green_s != snap_green);
    assign row_bit     = 8'd1 << snap_row;
    assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= ST_WAIT;
        else       state <= state_n;
    end

    // The snapshot cycle counts as the first stable sample, so capture fires
    // on the compare where cnt would step to SETTLE-1.
    always_comb begin
        state_n   = state;
        snap_load = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (sel_onehot) begin
                    state_n   = ST_SETTLE;
                    snap_load = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (sel_multi) begin
                    err_set = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (any_changed) begin
                    snap_load = 1'b1;
                    cnt_clr   = 1'b1;
                    if (!sel_onehot) begin
                        state_n = ST_WAIT;
                        err_set = sel_multi;
                    end
                end else if (cnt == CW'(SETTLE - 2)) begin
                    capture = 1'b1;
                    state_n = ST_HELD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_HELD: begin
                if (sel_changed) begin
                    snap_load = 1'b1;
                    cnt_clr   = 1'b1;
                    if (sel_onehot) begin
                        state_n = ST_SETTLE;
                    end else begin
                        state_n = ST_WAIT;
                        err_set = sel_multi;
                    end
                end
            end
            default: state_n = ST_WAIT;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            snap_sel     <= '0;
            snap_red     <= '0;
            snap_green   <= '0;
            snap_row     <= '0;
            cnt          <= '0;
            tcnt         <= '0;
            shadow_red   <= '0;
            shadow_green <= '0;
            seen         <= '0;
            done_pend    <= 1'b0;
            red_frame    <= '0;
            green_frame  <= '0;
            frame_valid  <= 1'b0;
            frame_count  <= '0;
            row_error    <= 1'b0;
            stale        <= 1'b0;
        end else begin
            if (snap_load) begin
                snap_sel   <= sel;
                snap_red   <= red_s;
                snap_green <= green_s;
                snap_row   <= row_index(sel);
            end

            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (err_set) row_error <= 1'b1;

            // Completion is flagged on the capture cycle and published on the
            // next one, so the frame includes the row just captured.
            done_pend   <= capture && ((seen | row_bit) == 8'hFF);
            frame_valid <= done_pend;
            if (done_pend) begin
                red_frame   <= shadow_red;
                green_frame <= shadow_green;
                frame_count <= frame_count + 8'd1;
                stale       <= 1'b0;
            end

            if (capture) begin
                shadow_red[{snap_row, 3'b000} +: 8]   <= snap_red;
                shadow_green[{snap_row, 3'b000} +: 8] <= snap_green;
                tcnt <= '0;
            end else if (timeout_hit) begin
                tcnt  <= '0;
                stale <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (capture)                        seen <= seen | row_bit;
            else if (done_pend || timeout_hit)  seen <= '0;
        end
    end

endmodule

// File: tb/tb_matrix_frame_capture.sv
// tb_matrix_frame_capture
//   Drives logical row/column segments into two instances (active-low and
//   active-high row select) and compares against a segment-level model:
//   a row segment held for at least SETTLE cycles is captured unless that
//   row activation was already captured; eight distinct rows make a frame.
module tb_matrix_frame_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  red_d = '0, green_d = '0, mask = '0;
    logic [7:0]  row_lo, row_hi;

    logic [63:0] red_f, green_f, red_f0, green_f0;
    logic        fv, fv0, err1, err0, stale1, stale0;
    logic [7:0]  cnt1, cnt0;

    assign row_lo = ~mask;
    assign row_hi = mask;

    matrix_frame_capture #(.ROW_ACTIVE_LOW(1'b1), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50(clk), .reset(reset), .red_driver(red_d), .green_driver(green_d),
        .row_sink(row_lo), .red_frame(red_f), .green_frame(green_f), .frame_valid(fv),
        .frame_count(cnt1), .row_error(err1), .stale(stale1)
    );

    matrix_frame_capture #(.ROW_ACTIVE_LOW(1'b0), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut0 (
        .CLOCK_50(clk), .reset(reset), .red_driver(red_d), .green_driver(green_d),
        .row_sink(row_hi), .red_frame(red_f0), .green_frame(green_f0), .frame_valid(fv0),
        .frame_count(cnt0), .row_error(err0), .stale(stale0)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed frame_valid events
    logic [63:0] obs_red[$], obs_green[$];
    logic [7:0]  obs_cnt[$];
    int unsigned obs_cyc[$];

    always @(negedge clk) begin
        if (fv) begin
            obs_red.push_back(red_f);
            obs_green.push_back(green_f);
            obs_cnt.push_back(cnt1);
            obs_cyc.push_back(cyc);
        end
    end

    // Reference model
    logic [63:0] m_red, m_green, m_last_red, m_last_green;
    logic [7:0]  m_seen, m_cnt, m_cur, m_lr, m_lg;
    bit          m_held, m_err;
    logic [63:0] exp_red[$], exp_green[$];
    logic [7:0]  exp_cnt[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_red = '0; m_green = '0; m_last_red = '0; m_last_green = '0;
        m_seen = '0; m_cnt = '0; m_cur = '0; m_lr = '0; m_lg = '0;
        m_held = 0; m_err = 0;
        exp_red.delete(); exp_green.delete(); exp_cnt.delete();
        obs_red.delete(); obs_green.delete(); obs_cnt.delete(); obs_cyc.delete();
    endtask

    task automatic do_reset();
        mask = '0; red_d = '0; green_d = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Apply one stable segment for len cycles and update the model.
    task automatic seg(input logic [7:0] m, input logic [7:0] r, input logic [7:0] g,
                       input int unsigned len, output bit cap);
        int row;
        mask = m; red_d = r; green_d = g;
        cap = 0;
        row = 0;
        if (m != m_cur) m_held = 0;
        if ($countones(m) > 1) begin
            m_err = 1;
        end else if ($countones(m) == 1 && len >= SETTLE && !m_held) begin
            for (int i = 0; i < 8; i++) if (m[i]) row = i;
            m_red[8*row +: 8]   = r;
            m_green[8*row +: 8] = g;
            m_seen[row] = 1'b1;
            m_held = 1;
            cap = 1;
            if (m_seen == 8'hFF) begin
                m_cnt = m_cnt + 8'd1;
                m_seen = '0;
                m_last_red = m_red;
                m_last_green = m_green;
                exp_red.push_back(m_red);
                exp_green.push_back(m_green);
                exp_cnt.push_back(m_cnt);
            end
        end
        m_cur = m; m_lr = r; m_lg = g;
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic scan_rows(input int first, input int last);
        bit cap;
        for (int r = first; r <= last; r++)
            seg(8'd1 << r, 8'($urandom), 8'($urandom), 8, cap);
    endtask

    // Blank the row lines long enough for every pending pulse to appear,
    // then match observed frame events against expected ones.
    task automatic check_frames(input string tag);
        bit cap;
        seg(8'h00, 8'h00, 8'h00, SETTLE + 8, cap);
        chk({tag, ":frames"}, 64'(obs_red.size()), 64'(exp_red.size()));
        while (obs_red.size() > 0 && exp_red.size() > 0) begin
            chk({tag, ":red"},   obs_red.pop_front(),   exp_red.pop_front());
            chk({tag, ":green"}, obs_green.pop_front(), exp_green.pop_front());
            chk({tag, ":count"}, 64'(obs_cnt.pop_front()), 64'(exp_cnt.pop_front()));
        end
        obs_red.delete(); obs_green.delete(); obs_cnt.delete(); obs_cyc.delete();
        exp_red.delete(); exp_green.delete(); exp_cnt.delete();
        chk({tag, ":frame_count"}, 64'(cnt1), 64'(m_cnt));
        chk({tag, ":red_frame"}, red_f, m_last_red);
        chk({tag, ":green_frame"}, green_f, m_last_green);
        chk({tag, ":ah_frame_count"}, 64'(cnt0), 64'(m_cnt));
        chk({tag, ":ah_red_frame"}, red_f0, m_last_red);
        chk({tag, ":ah_green_frame"}, green_f0, m_last_green);
    endtask

    initial begin
        bit          cap;
        int unsigned t7, lat, nocap;
        logic [7:0]  m, r, g;
        int unsigned len;

        // 1: reset then idle
        model_reset();
        do_reset();
        chk("rst_red", red_f, 64'd0);
        chk("rst_green", green_f, 64'd0);
        chk("rst_valid", 64'(fv), 64'd0);
        chk("rst_count", 64'(cnt1), 64'd0);
        chk("rst_err", 64'(err1), 64'd0);
        chk("rst_stale", 64'(stale1), 64'd0);
        chk("rst_err_ah", 64'(err0), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("stale_early", 64'(stale1), 64'd0);
        repeat (42) @(posedge clk);
        #1;
        chk("stale_timeout", 64'(stale1), 64'd1);
        chk("stale_timeout_ah", 64'(stale0), 64'd1);
        chk("idle_no_frame", 64'(obs_red.size()), 64'd0);

        // 2: fixed scan, red col 6, green = row index
        t7 = 0;
        for (int row = 0; row < 8; row++) begin
            if (row == 7) t7 = cyc;
            seg(8'd1 << row, 8'h40, 8'(row), 8, cap);
        end
        lat = (obs_cyc.size() > 0) ? obs_cyc[0] - t7 : 0;
        chk("latency", 64'(lat), 64'(3 + SETTLE));
        check_frames("scan");
        chk("scan_red_const", red_f, 64'h4040_4040_4040_4040);
        chk("scan_green_const", green_f, 64'h0706_0504_0302_0100);
        chk("scan_count_const", 64'(cnt1), 64'd1);
        chk("scan_stale_clr", 64'(stale1), 64'd0);
        chk("ah_green_const", green_f0, 64'h0706_0504_0302_0100);

        // 3: glitching row 3 is not captured until it holds still
        do_reset();
        scan_rows(0, 2);
        scan_rows(4, 7);
        for (int k = 0; k < 5; k++)
            seg(8'h08, (k % 2 == 0) ? 8'hA5 : 8'h5A, 8'h3C, 2, cap);
        seg(8'h00, 8'h00, 8'h00, 10, cap);
        chk("glitch_no_frame", 64'(obs_red.size()), 64'd0);
        seg(8'h08, 8'hC3, 8'h99, 6, cap);
        check_frames("glitch");
        chk("glitch_count", 64'(cnt1), 64'd1);

        // 4: two rows at once
        seg(8'h0C, 8'hFF, 8'hFF, 8, cap);
        chk("multi_err", 64'(err1), 64'd1);
        chk("multi_err_ah", 64'(err0), 64'd1);
        scan_rows(0, 7);
        check_frames("after_err");
        chk("err_sticky", 64'(err1), 64'd1);

        // 5: reset mid-scan drops the partial frame
        do_reset();
        scan_rows(0, 4);
        do_reset();
        chk("midrst_count", 64'(cnt1), 64'd0);
        chk("midrst_red", red_f, 64'd0);
        chk("midrst_err", 64'(err1), 64'd0);
        scan_rows(5, 7);
        seg(8'h00, 8'h00, 8'h00, 10, cap);
        chk("partial_no_frame", 64'(obs_red.size()), 64'd0);
        scan_rows(0, 7);
        check_frames("midrst");
        chk("midrst_count1", 64'(cnt1), 64'd1);

        // 6: 256 scans wrap the frame counter
        do_reset();
        for (int s = 0; s < 256; s++) scan_rows(0, 7);
        check_frames("wrap");
        chk("wrap_count", 64'(cnt1), 64'd0);

        // Random segments with short holds, blanking and multi-row drives
        do_reset();
        nocap = 0;
        for (int i = 0; i < 400; i++) begin
            int unsigned kind;
            kind = $urandom_range(9);
            len  = $urandom_range(8, 1);
            if (nocap >= 3) begin
                m = 8'd1 << $urandom_range(7);
                if (m == m_cur) m = {m[6:0], m[7]};
                len = 8;
            end else if (kind == 0) begin
                m = 8'h00;
            end else if (kind == 1) begin
                m = 8'($urandom) | 8'h81;
            end else begin
                m = 8'd1 << $urandom_range(7);
            end
            r = 8'($urandom);
            g = 8'($urandom);
            if (m == m_cur && r == m_lr && g == m_lg) r = r ^ 8'h01;
            seg(m, r, g, len, cap);
            nocap = cap ? 0 : nocap + 1;
        end
        check_frames("random");
        chk("random_err", 64'(err1), 64'(m_err));
        chk("random_err_ah", 64'(err0), 64'(m_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
